scan_decoder: RTL
=================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 3: select width, legal range 1..6.
REQ-002 Parameter HOLD_W, default 8: width of the per-output dwell count.
REQ-003 Derived constant OUT_W = 2**SEL_W, not overridable.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  command present.
REQ-007 in_ready  out  1  block can accept a command.
REQ-008 sel  in  SEL_W  start index, sampled on accept.
REQ-009 mode  in  1  0 = direct, 1 = scan; sampled on accept.
REQ-010 dir  in  1  scan direction, 0 = up, 1 = down; sampled on accept.
REQ-011 hold  in  HOLD_W  dwell in cycles, sampled on accept.
REQ-012 stop  in  1  abort the active hold or scan.
REQ-013 out  out  OUT_W  registered one-hot or all-zero decode output.
REQ-014 busy  out  1  high in HOLD or SCAN state.
REQ-015 wrap  out  1  one-cycle pulse on scan wrap-around.

Function
REQ-016 A command is accepted on a rising edge where in_valid && in_ready.
REQ-017 in_ready is 1 in IDLE and 0 in HOLD and SCAN.
REQ-018 States and transitions:
- IDLE -> HOLD on accept with mode=0 and hold!=0.
- IDLE -> SCAN on accept with mode=1.
- HOLD/SCAN -> IDLE on stop or on hold expiry.
REQ-019 Latency is one cycle: out = one-hot(sel) in the cycle after accept.
REQ-020 Direct mode, hold=0 (sticky):
- out latches one-hot(sel) and the state stays IDLE.
- out is held until the next accept replaces it.
REQ-021 Direct mode, hold!=0:
- out is asserted for exactly hold cycles, then clears to 0.
- in_ready returns to 1 in the same cycle out clears.
REQ-022 Scan mode dwell:
- Each index is shown for max(hold,1) cycles.
- The index then steps +1 (dir=0) or -1 (dir=1) modulo OUT_W.
REQ-023 wrap pulses for one cycle, coincident with the first cycle out shows the wrapped index (OUT_W-1 -> 0 up, 0 -> OUT_W-1 down).
REQ-024 A scan runs until stop; it never self-terminates.
REQ-025 stop handling:
- In HOLD/SCAN, stop clears out to 0 and enters IDLE next cycle.
- In IDLE, stop is ignored and a sticky out is preserved.
REQ-026 stop and in_valid in the same IDLE cycle: the command is accepted and stop is ignored.
REQ-027 A sticky output is cleared by any subsequent accept, replaced by the new decode.
REQ-028 out is never multi-hot in any cycle.
REQ-029 busy = (state != IDLE), registered.

Reset
REQ-030 While rst_n=0: state=IDLE, out=0, busy=0, wrap=0, dwell counter=0, index=0; in_ready=1 after rst_n releases.
REQ-031 Reset asserted mid-HOLD or mid-SCAN aborts immediately, with no completion pulse.

Configuration
REQ-032 Macro SCAN_DECODER_SCAN_EN, defined: scan mode as specified.
REQ-033 Macro SCAN_DECODER_SCAN_EN, undefined:
- mode is ignored and treated as 0; wrap is tied to 0.
- Scan state, direction and wrap logic are absent.

Structure
REQ-034 Shared package scan_decoder_pkg holds the state enum (IDLE, HOLD, SCAN) and the mode and direction constants.
REQ-035 One sub-module onehot_dec (combinational SEL_W -> 2**SEL_W) is instantiated once; the index register and dwell counter live in scan_decoder.

Verification (SEL_W=3, HOLD_W=8)
REQ-036 Direct sticky: accept sel=5, hold=0 -> out=8'h20 next cycle, held indefinitely, in_ready=1.
REQ-037 Direct timed: accept sel=2, hold=3 -> out=8'h04 for 3 cycles, then 0; busy high for 3 cycles.
REQ-038 Scan up: accept sel=6, mode=1, dir=0, hold=2 -> out 8'h40,8'h40,8'h80,8'h80,8'h01 (wrap=1 on first 8'h01) ...
REQ-039 Scan down, hold=0: accept sel=1, dir=1 -> out 8'h02, 8'h01, 8'h80 (wrap=1), 8'h40 at one per cycle; stop -> out=0, IDLE next cycle.
REQ-040 Stop during direct sel=3, hold=10 at cycle 4 -> out=0 next cycle; next accept is taken the cycle after.
REQ-041 Reset asserted mid-scan -> out=0, busy=0, wrap=0 immediately; with SCAN_DECODER_SCAN_EN undefined, mode=1 behaves as REQ-037.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan decoder.
// State encoding plus mode and direction values.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational index to one-hot decoder.
// Width follows the select width of the parent.
module onehot_dec
    import scan_decoder_pkg::*;
#(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dec
);

    // Exactly one bit set for every select value
    always_comb begin
        dec      = '0;
        dec[sel] = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Select decoder with sticky, timed-hold and scanning modes.
// Scan mode present only when SCAN_DECODER_SCAN_EN is defined.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter  int SEL_W  = 3,
    parameter  int HOLD_W = 8,
    localparam int OUT_W  = 2**SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic              dir,
    input  logic [HOLD_W-1:0] hold,
    input  logic              stop,
    output logic [OUT_W-1:0]  out,
    output logic              busy,
    output logic              wrap
);

    state_t             state;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W-1:0]   dec_sel;
    logic [OUT_W-1:0]   dec_out;
    logic [HOLD_W-1:0]  cnt;
    logic               accept;
    logic               scan_req;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

`ifdef SCAN_DECODER_SCAN_EN
    logic [HOLD_W-1:0]  reload;
    logic [SEL_W-1:0]   nxt_idx;
    logic               scan_dir;
    logic               nxt_wrap;
    logic               wrap_q;

    assign scan_req = (mode == MODE_SCAN);
    assign wrap     = wrap_q;

    // Next scan position and whether stepping to it wraps
    always_comb begin
        nxt_idx  = idx + SEL_W'(1);
        nxt_wrap = (idx == '1);
        if (scan_dir == DIR_DOWN) begin
            nxt_idx  = idx - SEL_W'(1);
            nxt_wrap = (idx == '0);
        end
    end

    assign dec_sel = (state == IDLE) ? sel : nxt_idx;
`else
    logic unused_ok;

    assign scan_req  = 1'b0;
    assign wrap      = 1'b0;
    assign dec_sel   = sel;
    assign unused_ok = ^{mode, dir, idx};
`endif

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel (dec_sel),
        .dec (dec_out)
    );

    // Control FSM with registered decode, busy and wrap outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out      <= '0;
            busy     <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
`ifdef SCAN_DECODER_SCAN_EN
            reload   <= '0;
            scan_dir <= DIR_UP;
            wrap_q   <= 1'b0;
`endif
        end else begin
`ifdef SCAN_DECODER_SCAN_EN
            wrap_q <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        idx <= sel;
                        out <= dec_out;
                        if (scan_req) begin
                            state <= SCAN;
                            busy  <= 1'b1;
                            cnt   <= (hold == '0) ? '0 : hold - HOLD_W'(1);
`ifdef SCAN_DECODER_SCAN_EN
                            reload   <= (hold == '0) ? '0 : hold - HOLD_W'(1);
                            scan_dir <= dir;
`endif
                        end else if (hold != '0) begin
                            state <= HOLD;
                            busy  <= 1'b1;
                            cnt   <= hold - HOLD_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (stop || cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        out   <= '0;
                    end else begin
                        cnt <= cnt - HOLD_W'(1);
                    end
                end
`ifdef SCAN_DECODER_SCAN_EN
                SCAN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        out   <= '0;
                    end else if (cnt == '0) begin
                        idx    <= nxt_idx;
                        out    <= dec_out;
                        cnt    <= reload;
                        wrap_q <= nxt_wrap;
                    end else begin
                        cnt <= cnt - HOLD_W'(1);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    out   <= '0;
                end
            endcase
        end
    end

endmodule
